// File: rtl/skewed_weight_buffer_if.sv
// Load-side handshake and skewed output lanes of the weight staging buffer.
// The loader/array side uses master; the buffer itself uses slave.
interface skewed_weight_buffer_if #(
    parameter int ARRAYWIDTH = 4,
    parameter int DATASIZE   = 8
);
    logic                           in_valid;
    logic                           in_ready;
    logic [ARRAYWIDTH*DATASIZE-1:0] in_weight;
    logic [ARRAYWIDTH-1:0]          out_valid;
    logic [ARRAYWIDTH*DATASIZE-1:0] out_weight;

    modport master (
        output in_valid, in_weight,
        input  in_ready, out_valid, out_weight
    );

    modport slave (
        input  in_valid, in_weight,
        output in_ready, out_valid, out_weight
    );
endinterface

// File: rtl/skewed_weight_buffer.sv
// Holds one tile of weights (DEPTH rows of ARRAYWIDTH words) and replays it
// column-skewed: lane i lags lane 0 by i cycles.
module skewed_weight_buffer #(
    parameter int ARRAYWIDTH = 4,
    parameter int DATASIZE   = 8,
    parameter int DEPTH      = 4,
    parameter int REVERSE    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         start,
    skewed_weight_buffer_if.slave        bus,
    output logic                         full,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH+1)-1:0]   fill_level
);
    localparam int WW = ARRAYWIDTH * DATASIZE;
    localparam int FW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + ARRAYWIDTH);

    localparam logic [FW-1:0] FILL_LAST  = FW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEPTH + ARRAYWIDTH - 1);
    localparam logic [CW-1:0] CNT_ISSUES = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FULL, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt;
    logic              accept, issue, last;
    logic [IW-1:0]     wr_idx, rd_idx;
    logic [WW-1:0]     rd_row;
    logic [WW-1:0]     mem [DEPTH];
    logic [ARRAYWIDTH-1:0] lane_valid;
    logic [WW-1:0]         lane_word;

    assign bus.in_ready = rst && (state_q == S_IDLE || state_q == S_LOAD);
    assign accept       = bus.in_valid && bus.in_ready && !clear;
    assign last         = (cnt == CNT_LAST);
    assign issue        = (state_q == S_DRAIN) && (cnt < CNT_ISSUES);
    assign wr_idx       = fill_level[IW-1:0];
    assign rd_idx       = (REVERSE != 0) ? (IW'(DEPTH - 1) - cnt[IW-1:0]) : cnt[IW-1:0];
    assign rd_row       = mem[rd_idx];

    assign full           = (state_q == S_FULL);
    assign busy           = |lane_valid;
    assign bus.out_valid  = lane_valid;
    assign bus.out_weight = lane_word;

    // NOTE: every output of this block gets a default before the case, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_LOAD: if (accept) state_d = (fill_level == FILL_LAST) ? S_FULL : S_LOAD;
                S_FULL:         if (start)  state_d = S_DRAIN;
                S_DRAIN:        if (last)   state_d = S_FULL;
                default:                    state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fill_level <= '0;
            cnt        <= '0;
            done       <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= !clear && (state_q == S_DRAIN) && last;
            if (clear)       fill_level <= '0;
            else if (accept) fill_level <= fill_level + 1'b1;
            if (state_q == S_DRAIN && !last && !clear) cnt <= cnt + 1'b1;
            else                                       cnt <= '0;
        end
    end

    // NOTE: tile storage has no reset; fill_level alone decides what is valid.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_idx] <= bus.in_weight;
    end

    // Lane g: one capture stage plus g delay stages. Idle slots carry zero.
    for (genvar g = 0; g < ARRAYWIDTH; g++) begin : g_lane
        logic [DATASIZE-1:0] data_q [g+1];
        logic [g:0]          valid_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst || clear) begin
                valid_q <= '0;
                for (int j = 0; j <= g; j++) data_q[j] <= '0;
            end else begin
                valid_q[0] <= issue;
                data_q[0]  <= issue ? rd_row[g*DATASIZE +: DATASIZE] : '0;
                for (int j = 1; j <= g; j++) begin
                    valid_q[j] <= valid_q[j-1];
                    data_q[j]  <= data_q[j-1];
                end
            end
        end

        assign lane_valid[g]                     = valid_q[g];
        assign lane_word[g*DATASIZE +: DATASIZE] = data_q[g];
    end
endmodule

// File: tb/tb_skewed_weight_buffer.sv
// Directed bench: two instances (forward and reversed row order) share one
// stimulus stream; drain cycles are checked against a hand-written table.
module tb_skewed_weight_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear, start, in_valid;
    logic [31:0] in_weight;
    logic        full0, busy0, done0, full1, busy1, done1;
    logic [2:0]  fill0, fill1;
    int          n_vec, n_err;

    always #5 clk = ~clk;

    skewed_weight_buffer_if #(.ARRAYWIDTH(4), .DATASIZE(8)) bus0 ();
    skewed_weight_buffer_if #(.ARRAYWIDTH(4), .DATASIZE(8)) bus1 ();
    assign bus0.in_valid  = in_valid;
    assign bus0.in_weight = in_weight;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_weight = in_weight;

    skewed_weight_buffer #(.ARRAYWIDTH(4), .DATASIZE(8), .DEPTH(4), .REVERSE(0)) dut0 (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .bus(bus0),
        .full(full0), .busy(busy0), .done(done0), .fill_level(fill0)
    );
    skewed_weight_buffer #(.ARRAYWIDTH(4), .DATASIZE(8), .DEPTH(4), .REVERSE(1)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .bus(bus1),
        .full(full1), .busy(busy1), .done(done1), .fill_level(fill1)
    );

    typedef struct {
        logic [3:0]  v0;
        logic [31:0] w0;
        logic [3:0]  v1;
        logic [31:0] w1;
        logic        busy;
        logic        done;
        logic        full;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] row_word(input int r, input logic [7:0] ofs);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = 8'(16*r + i) + ofs;
        return w;
    endfunction

    function automatic logic [31:0] add_ofs(input logic [31:0] w, input logic [3:0] v,
                                            input logic [7:0] ofs);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) if (v[i]) r[8*i +: 8] = w[8*i +: 8] + ofs;
        return r;
    endfunction

    task automatic load_tile(input logic [7:0] ofs);
        in_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            in_weight = row_word(r, ofs);
            step();
        end
        in_valid = 1'b0;
        check("load fill_level", 32'(fill0), 32'd4);
        check("load full", 32'(full0), 32'd1);
    endtask

    // Starts a drain and checks cycles S..S+8; returns in the done cycle.
    task automatic drain(input logic [7:0] ofs);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("c%0d out_valid fwd", c), 32'(bus0.out_valid), 32'(tbl[c].v0));
            check($sformatf("c%0d out_weight fwd", c), bus0.out_weight,
                  add_ofs(tbl[c].w0, tbl[c].v0, ofs));
            check($sformatf("c%0d out_valid rev", c), 32'(bus1.out_valid), 32'(tbl[c].v1));
            check($sformatf("c%0d out_weight rev", c), bus1.out_weight,
                  add_ofs(tbl[c].w1, tbl[c].v1, ofs));
            check($sformatf("c%0d busy", c), 32'(busy0), 32'(tbl[c].busy));
            check($sformatf("c%0d done fwd", c), 32'(done0), 32'(tbl[c].done));
            check($sformatf("c%0d done rev", c), 32'(done1), 32'(tbl[c].done));
            check($sformatf("c%0d full", c), 32'(full0), 32'(tbl[c].full));
            if (c < 8) step();
        end
    endtask

    initial begin
        logic seen_done, seen_valid;
        //          v0       w0            v1       w1            busy done full
        tbl[0] = '{4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{4'b0001, 32'h0000_0000, 4'b0001, 32'h0000_0030, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{4'b0011, 32'h0000_0110, 4'b0011, 32'h0000_3120, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{4'b0111, 32'h0002_1120, 4'b0111, 32'h0032_2110, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{4'b1111, 32'h0312_2130, 4'b1111, 32'h3322_1100, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{4'b1110, 32'h1322_3100, 4'b1110, 32'h2312_0100, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{4'b1100, 32'h2332_0000, 4'b1100, 32'h1302_0000, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{4'b1000, 32'h3300_0000, 4'b1000, 32'h0300_0000, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1};

        n_vec = 0; n_err = 0;
        clear = 1'b0; start = 1'b0; in_valid = 1'b0; in_weight = '0;

        // Reset state.
        step(); step();
        check("reset in_ready", 32'(bus0.in_ready), 32'd0);
        check("reset fill_level", 32'(fill0), 32'd0);
        check("reset full", 32'(full0), 32'd0);
        check("reset out_valid", 32'(bus0.out_valid), 32'd0);
        @(negedge clk) rst = 1'b1;
        step();
        check("post-reset in_ready", 32'(bus0.in_ready), 32'd1);

        // Six beats offered, only four taken; start during LOAD ignored.
        in_valid = 1'b1;
        in_weight = row_word(0, 8'h00); step();
        check("bp fill 1", 32'(fill0), 32'd1);
        in_weight = row_word(1, 8'h00); start = 1'b1; step(); start = 1'b0;
        check("bp fill 2", 32'(fill0), 32'd2);
        check("start in LOAD busy", 32'(busy0), 32'd0);
        in_weight = row_word(2, 8'h00); step();
        check("bp fill 3", 32'(fill0), 32'd3);
        check("bp in_ready LOAD", 32'(bus0.in_ready), 32'd1);
        in_weight = row_word(3, 8'h00); step();
        check("bp fill 4", 32'(fill0), 32'd4);
        check("bp full", 32'(full0), 32'd1);
        check("bp in_ready FULL", 32'(bus0.in_ready), 32'd0);
        in_weight = row_word(4, 8'h00); step();
        check("bp beat5 ignored", 32'(fill0), 32'd4);
        in_weight = row_word(5, 8'h00); step();
        check("bp beat6 ignored", 32'(fill1), 32'd4);
        in_valid = 1'b0;
        check("start in LOAD no drain", 32'(bus0.out_valid), 32'd0);

        // Back-to-back replay of the retained tile.
        drain(8'h00);
        drain(8'h00);
        step();
        check("after replay done", 32'(done0), 32'd0);
        check("after replay full", 32'(full0), 32'd1);

        // clear and start together in FULL: clear wins.
        clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
        check("clr+start fill", 32'(fill0), 32'd0);
        check("clr+start full", 32'(full0), 32'd0);
        check("clr+start in_ready", 32'(bus0.in_ready), 32'd1);
        step();
        check("clr+start no drain", 32'(bus0.out_valid), 32'd0);

        // Fresh tile after clear.
        load_tile(8'h80);
        drain(8'h80);
        step();

        // Abort mid-drain.
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        check("abort pre out_valid", 32'(bus0.out_valid), 32'b0111);
        clear = 1'b1; step(); clear = 1'b0;
        check("abort out_valid fwd", 32'(bus0.out_valid), 32'd0);
        check("abort out_weight fwd", bus0.out_weight, 32'd0);
        check("abort out_valid rev", 32'(bus1.out_valid), 32'd0);
        check("abort out_weight rev", bus1.out_weight, 32'd0);
        check("abort in_ready", 32'(bus0.in_ready), 32'd1);
        check("abort fill", 32'(fill0), 32'd0);
        check("abort busy", 32'(busy0), 32'd0);
        seen_done = 1'b0; seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen_done  = seen_done | done0 | done1;
            seen_valid = seen_valid | (|bus0.out_valid) | (|bus1.out_valid);
            step();
        end
        check("abort no done", 32'(seen_done), 32'd0);
        check("abort stays flushed", 32'(seen_valid), 32'd0);

        // Async reset between edges mid-drain.
        load_tile(8'h00);
        start = 1'b1; step(); start = 1'b0;
        step(); step();
        check("pre-rst out_valid", 32'(bus0.out_valid), 32'b0011);
        #2 rst = 1'b0;
        #1;
        check("async out_valid", 32'(bus0.out_valid), 32'd0);
        check("async out_weight", bus0.out_weight, 32'd0);
        check("async busy", 32'(busy0), 32'd0);
        check("async full", 32'(full0), 32'd0);
        check("async fill", 32'(fill0), 32'd0);
        check("async in_ready", 32'(bus0.in_ready), 32'd0);
        @(negedge clk) rst = 1'b1;
        step();
        check("rst release in_ready", 32'(bus0.in_ready), 32'd1);
        load_tile(8'h40);
        drain(8'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/skewed_weight_buffer.md
# skewed_weight_buffer

Parametrised weight staging buffer between the weight loader and the top edge of the systolic array. It accepts a full tile of weights, one row (ARRAYWIDTH words) per handshake beat, and holds the tile. On request it streams the tile out column-skewed: column i is delayed i cycles. The held tile can be replayed for multiple activation passes without reloading.

## Interface
- ARRAYWIDTH, 4, number of array columns / output lanes
- DATASIZE, 8, bits per weight word
- DEPTH, 4, rows per tile (≥1)
- REVERSE, 0, 0: row 0 streamed first; 1: row DEPTH-1 streamed first
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort/empty, priority over all other inputs
- in_valid  in  1  load beat valid
- in_ready  out  1  buffer can accept a beat
- in_weight  in  ARRAYWIDTH*DATASIZE  one row; lane i = bits [(i+1)*DATASIZE-1 : i*DATASIZE]
- start  in  1  begin one skewed drain of the held tile
- full  out  1  complete tile held, drain accepted
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse at drain end
- fill_level  out  $clog2(DEPTH+1)  rows currently held
- out_valid  out  ARRAYWIDTH  per-lane valid
- out_weight  out  ARRAYWIDTH*DATASIZE  per-lane weight, same lane packing as in_weight

## Operation
- States: IDLE (empty), LOAD (partial), FULL (tile held), DRAIN.
- Reset (rst low) or clear: state IDLE, fill_level 0, in_ready 0 during reset then 1, full/busy/done 0, out_valid all 0, out_weight 0. Storage contents are not cleared; they are treated as empty.
- Beat accepted when in_valid && in_ready. The row is written to index fill_level, and fill_level increments.
- in_ready = 1 in IDLE and LOAD only.
- IDLE→LOAD on the first beat. LOAD→FULL on the DEPTH-th beat. With DEPTH=1, IDLE→FULL directly.
- full = 1 only in FULL. start is ignored in any other state.
- FULL + start → DRAIN. A row counter r runs 0..DEPTH-1. It reads row r, or row DEPTH-1-r when REVERSE=1.
- Lane i passes through i register stages (lane 0: 0 extra). Result: lane i presents row k exactly i cycles after lane 0 presents row k.
- Lane output is 0 and out_valid[i] is 0 whenever that lane has no valid word.
- DRAIN→FULL after the last word leaves lane ARRAYWIDTH-1, with a done pulse. Tile is retained and fill_level stays DEPTH, so start may replay it.
- FULL + clear → IDLE. This is the only path to reloading.
- clear during DRAIN aborts: all lane pipelines flushed, no done pulse.
- Simultaneous start and clear: clear wins. in_valid during FULL/DRAIN: no effect (in_ready 0).

## Timing
- Load: the beat accepted at edge E is counted in fill_level after E. full rises after the edge accepting beat DEPTH. in_ready falls in the same cycle.
- start sampled high at edge S (state FULL). busy = 1 from S+1 through the cycle of the last valid output.
- Lane i, row k (stream order): valid in the cycle after edge S+1+i+k, for k = 0..DEPTH-1.
- Lane 0 valid cycles S+1..S+DEPTH. Lane ARRAYWIDTH-1 valid cycles S+ARRAYWIDTH..S+DEPTH+ARRAYWIDTH-1.
- Total drain: DEPTH+ARRAYWIDTH-1 cycles.
- done high for exactly one cycle, S+DEPTH+ARRAYWIDTH. full returns to 1 in that same cycle. Earliest next accepted start is at the edge ending that cycle.
- Async reset assertion forces all outputs to reset values immediately, independent of clk. Deassertion takes effect at the next edge.

## Test plan
- Load/drain, ARRAYWIDTH=4, DEPTH=4, REVERSE=0:
  - Stimulus: rows R0..R3, lane word = 16*row+lane; start one cycle after full.
  - Required: lane 0 outputs 0x00,0x10,0x20,0x30 in cycles S+1..S+4.
  - Required: lane 3 outputs 0x03,0x13,0x23,0x33 in cycles S+4..S+7.
  - Required: done at S+8, full=1 again.
- REVERSE=1, same data: lane 0 outputs 0x30,0x20,0x10,0x00 from S+1; lane 2 outputs the same sequence from S+3.
- Backpressure and ignored inputs:
  - Stimulus: in_valid held high for 6 beats.
  - Required: only 4 accepted; fill_level 1,2,3,4; in_ready 0 after the 4th.
  - Required: start while LOAD is ignored (busy stays 0).
- Replay and clear:
  - Stimulus: two back-to-back drains.
  - Required: identical output streams from the retained tile.
  - Stimulus: clear in FULL, then load a new tile.
  - Required: fill_level 0; new data drained.
- Abort:
  - Stimulus: clear at S+3 mid-drain.
  - Required: next cycle all out_valid 0, out_weight 0, state IDLE, no done pulse.
  - Stimulus: clear and start asserted together.
  - Required: clear wins.
- Async reset:
  - Stimulus: rst low between edges mid-drain.
  - Required: out_valid, busy, full, fill_level 0 immediately.
  - Required: after release, in_ready 1 and a fresh load works.
